// File: rtl/tick_scheduler_if.sv
// -----------------------------------------------------------------------------
// tick_scheduler_if
// Configuration port of the tick scheduler. Uses a valid/ready handshake and
// returns a one-cycle error strobe.
//   cfg_valid  : requester has a config request this cycle
//   cfg_ready  : scheduler can accept a request this cycle
//   cfg_ch     : target channel index
//   cfg_enable : 1 = run channel, 0 = stop channel
//   cfg_period : tick period in clk cycles
//   cfg_err    : one-cycle pulse, the last accepted request was rejected
// Modports: master drives requests, slave is the scheduler.
// -----------------------------------------------------------------------------
interface tick_scheduler_if #(
  parameter int WIDTH = 16
) ();
  logic             cfg_valid;
  logic             cfg_ready;
  logic [2:0]       cfg_ch;
  logic             cfg_enable;
  logic [WIDTH-1:0] cfg_period;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_enable, cfg_period,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_enable, cfg_period,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/tick_scheduler.sv
// -----------------------------------------------------------------------------
// tick_scheduler
// Multi-channel periodic tick generator. Each channel emits a one-cycle strobe
// every 'period' clk cycles. Channels are programmed at run time through the
// config interface; period changes on a running channel are staged and only
// take effect at that channel's wrap, so no short or long interval is produced.
// Ports:
//   clk       : system clock, rising edge
//   resetn    : synchronous active-low reset
//   sync_in   : restart all running counters in phase
//   cfg       : config interface (slave side)
//   tick      : per-channel one-cycle strobe
//   pend_busy : channel holds a staged period not yet applied
// -----------------------------------------------------------------------------
module tick_scheduler #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sync_in,
  tick_scheduler_if.slave   cfg,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend_busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_e;

  // One bit wider than cfg_ch so NUM_CH=8 is representable.
  localparam logic [3:0] CH_LIMIT = 4'(NUM_CH);

  state_e state_q, state_d;

  // Request latched on the handshake, validated and applied in COMMIT.
  logic [2:0]       req_ch_q, req_ch_d;
  logic             req_en_q, req_en_d;
  logic [WIDTH-1:0] req_period_q, req_period_d;

  logic [NUM_CH-1:0] active_en_q, active_en_d;
  logic [WIDTH-1:0]  active_period_q [NUM_CH];
  logic [WIDTH-1:0]  active_period_d [NUM_CH];
  logic [WIDTH-1:0]  count_q [NUM_CH];
  logic [WIDTH-1:0]  count_d [NUM_CH];
  logic [NUM_CH-1:0] pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0]  pend_period_q [NUM_CH];
  logic [WIDTH-1:0]  pend_period_d [NUM_CH];

  logic handshake;
  logic req_bad;
  logic commit_ok;

  assign handshake = cfg.cfg_valid && cfg.cfg_ready;
  assign req_bad   = ({1'b0, req_ch_q} >= CH_LIMIT) ||
                     (req_en_q && (req_period_q == '0));
  assign commit_ok = (state_q == COMMIT) && !req_bad;

  assign cfg.cfg_ready = (state_q == IDLE);
  assign cfg.cfg_err   = (state_q == COMMIT) && req_bad;
  assign pend_busy     = pend_valid_q;

  // ---------------------------------------------------------------------------
  // Config FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d      = state_q;
    req_ch_d     = req_ch_q;
    req_en_d     = req_en_q;
    req_period_d = req_period_q;
    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d      = COMMIT;
          req_ch_d     = cfg.cfg_ch;
          req_en_d     = cfg.cfg_enable;
          req_period_d = cfg.cfg_period;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Tick decode: period-1 is only meaningful while enabled (period >= 1).
  // ---------------------------------------------------------------------------
  always_comb begin
    tick = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      tick[i] = active_en_q[i] && (count_q[i] == active_period_q[i] - WIDTH'(1));
    end
  end

  // ---------------------------------------------------------------------------
  // Channel next state. Counter/wrap handling first, then a committed config
  // for the channel overrides it.
  // ---------------------------------------------------------------------------
  always_comb begin
    active_en_d  = active_en_q;
    pend_valid_d = pend_valid_q;
    for (int i = 0; i < NUM_CH; i++) begin
      active_period_d[i] = active_period_q[i];
      count_d[i]         = count_q[i];
      pend_period_d[i]   = pend_period_q[i];

      if (active_en_q[i]) begin
        if (tick[i]) begin
          // Wrap: the only point where a staged period may take over, so the
          // old period governs right up to and including this tick.
          count_d[i] = '0;
          if (pend_valid_q[i]) begin
            active_period_d[i] = pend_period_q[i];
            pend_valid_d[i]    = 1'b0;
          end
        end else if (sync_in) begin
          count_d[i] = '0;
        end else begin
          count_d[i] = count_q[i] + WIDTH'(1);
        end
      end

      if (commit_ok && (int'(req_ch_q) == i)) begin
        if (!active_en_q[i]) begin
          active_en_d[i]     = req_en_q;
          active_period_d[i] = req_period_q;
          count_d[i]         = '0;
          pend_valid_d[i]    = 1'b0;
        end else if (!req_en_q) begin
          active_en_d[i]  = 1'b0;
          count_d[i]      = '0;
          pend_valid_d[i] = 1'b0;
        end else begin
          // Running channel: stage the new period; a later write overwrites it.
          pend_valid_d[i]  = 1'b1;
          pend_period_d[i] = req_period_q;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every register samples the
    // pre-edge values regardless of statement order.
    if (!resetn) begin
      state_q      <= IDLE;
      req_ch_q     <= '0;
      req_en_q     <= 1'b0;
      req_period_q <= '0;
      active_en_q  <= '0;
      pend_valid_q <= '0;
      // NOTE: the per-channel arrays are architectural state (a reset must
      // leave every channel stopped with no staged config), so they are reset
      // element by element rather than left uninitialised like a RAM.
      for (int i = 0; i < NUM_CH; i++) begin
        active_period_q[i] <= '0;
        count_q[i]         <= '0;
        pend_period_q[i]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      req_ch_q     <= req_ch_d;
      req_en_q     <= req_en_d;
      req_period_q <= req_period_d;
      active_en_q  <= active_en_d;
      pend_valid_q <= pend_valid_d;
      for (int i = 0; i < NUM_CH; i++) begin
        active_period_q[i] <= active_period_d[i];
        count_q[i]         <= count_d[i];
        pend_period_q[i]   <= pend_period_d[i];
      end
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tick_scheduler
// Self-checking bench for tick_scheduler. A cycle-by-cycle vector table covers
// basic programming, rejects, P=1, disable and staged period changes; hand
// written sequences cover sync_in alignment and reset with a staged config.
// Inputs are driven 1 time unit after the rising edge, outputs are sampled on
// the falling edge of the same cycle.
// -----------------------------------------------------------------------------
module tb_tick_scheduler;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 16;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              sync_in = 1'b0;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pend_busy;

  tick_scheduler_if #(.WIDTH(WIDTH)) cfg_if ();

  tick_scheduler #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .sync_in   (sync_in),
    .cfg       (cfg_if),
    .tick      (tick),
    .pend_busy (pend_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic             v;
    logic [2:0]       ch;
    logic             en;
    logic [WIDTH-1:0] p;
    logic             sy;
    logic [3:0]       tk;
    logic [3:0]       pb;
    logic             rdy;
    logic             err;
  } vec_t;

  vec_t vecs[$];
  int   b_start;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] ch, input logic en,
                       input logic [WIDTH-1:0] p, input logic sy);
    cfg_if.cfg_valid  = v;
    cfg_if.cfg_ch     = ch;
    cfg_if.cfg_enable = en;
    cfg_if.cfg_period = p;
    sync_in           = sy;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    drive(1'b0, 3'd0, 1'b0, '0, 1'b0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst.tick", 32'(tick), 32'h0);
    check("rst.pend_busy", 32'(pend_busy), 32'h0);
    check("rst.cfg_ready", 32'(cfg_if.cfg_ready), 32'h1);
    check("rst.cfg_err", 32'(cfg_if.cfg_err), 32'h0);
    next_cycle();
    resetn = 1'b1;
    next_cycle();
  endtask

  function automatic vec_t mk(input logic v, input logic [2:0] ch, input logic en,
                              input logic [WIDTH-1:0] p, input logic sy,
                              input logic [3:0] tk, input logic [3:0] pb,
                              input logic rdy, input logic err);
    vec_t r;
    r.v = v; r.ch = ch; r.en = en; r.p = p; r.sy = sy;
    r.tk = tk; r.pb = pb; r.rdy = rdy; r.err = err;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Phase A: ch0 P=4, rejects (ch2 P=0, ch6), ch3 P=1 then disable.
    vecs.push_back(mk(1, 3'd0, 1, 16'd4, 0, 4'h0, 4'h0, 1, 0)); // T: accept ch0
    vecs.push_back(mk(0, 3'd0, 0, 16'd0, 0, 4'h0, 4'h0, 0, 0)); // commit
    vecs.push_back(mk(1, 3'd2, 1, 16'd0, 0, 4'h0, 4'h0, 1, 0)); // ch2 P=0
    vecs.push_back(mk(0, 3'd0, 0, 16'd0, 0, 4'h0, 4'h0, 0, 1)); // reject
    vecs.push_back(mk(1, 3'd6, 1, 16'd5, 0, 4'h0, 4'h0, 1, 0)); // ch6
    vecs.push_back(mk(0, 3'd0, 0, 16'd0, 0, 4'h1, 4'h0, 0, 1)); // T+5 tick, reject
    vecs.push_back(mk(1, 3'd3, 1, 16'd1, 0, 4'h0, 4'h0, 1, 0)); // ch3 P=1
    vecs.push_back(mk(0, 3'd0, 0, 16'd0, 0, 4'h0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 3'd0, 0, 16'd0, 0, 4'h8, 4'h0, 1, 0));
    vecs.push_back(mk(0, 3'd0, 0, 16'd0, 0, 4'h9, 4'h0, 1, 0)); // T+9
    vecs.push_back(mk(0, 3'd0, 0, 16'd0, 0, 4'h8, 4'h0, 1, 0));
    vecs.push_back(mk(1, 3'd3, 0, 16'd0, 0, 4'h8, 4'h0, 1, 0)); // disable ch3
    vecs.push_back(mk(0, 3'd0, 0, 16'd0, 0, 4'h8, 4'h0, 0, 0));
    vecs.push_back(mk(0, 3'd0, 0, 16'd0, 0, 4'h1, 4'h0, 1, 0)); // T+13, ch3 off
    vecs.push_back(mk(0, 3'd0, 0, 16'd0, 0, 4'h0, 4'h0, 1, 0));
    // Phase B: ch1 P=3 -> staged P=5, then P=2 overwritten by P=7.
    b_start = vecs.size();
    vecs.push_back(mk(1, 3'd1, 1, 16'd3, 0, 4'h0, 4'h0, 1, 0));
    vecs.push_back(mk(0, 3'd0, 0, 16'd0, 0, 4'h0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 3'd0, 0, 16'd0, 0, 4'h0, 4'h0, 1, 0));
    vecs.push_back(mk(0, 3'd0, 0, 16'd0, 0, 4'h0, 4'h0, 1, 0));
    vecs.push_back(mk(0, 3'd0, 0, 16'd0, 0, 4'h2, 4'h0, 1, 0));
    vecs.push_back(mk(1, 3'd1, 1, 16'd5, 0, 4'h0, 4'h0, 1, 0)); // stage P=5
    vecs.push_back(mk(0, 3'd0, 0, 16'd0, 0, 4'h0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 3'd0, 0, 16'd0, 0, 4'h2, 4'h2, 1, 0)); // old-period tick
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 3'd0, 0, 16'd0, 0, 4'h0, 4'h0, 1, 0));
    vecs.push_back(mk(0, 3'd0, 0, 16'd0, 0, 4'h2, 4'h0, 1, 0)); // +5
    vecs.push_back(mk(1, 3'd1, 1, 16'd2, 0, 4'h0, 4'h0, 1, 0)); // stage P=2
    vecs.push_back(mk(0, 3'd0, 0, 16'd0, 0, 4'h0, 4'h0, 0, 0));
    vecs.push_back(mk(1, 3'd1, 1, 16'd7, 0, 4'h0, 4'h2, 1, 0)); // overwrite P=7
    vecs.push_back(mk(0, 3'd0, 0, 16'd0, 0, 4'h0, 4'h2, 0, 0));
    vecs.push_back(mk(0, 3'd0, 0, 16'd0, 0, 4'h2, 4'h2, 1, 0)); // +5, apply 7
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0, 3'd0, 0, 16'd0, 0, 4'h0, 4'h0, 1, 0));
    vecs.push_back(mk(0, 3'd0, 0, 16'd0, 0, 4'h2, 4'h0, 1, 0)); // +7

    drive(1'b0, 3'd0, 1'b0, '0, 1'b0);
    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 0 || i == b_start) do_reset();
      drive(vecs[i].v, vecs[i].ch, vecs[i].en, vecs[i].p, vecs[i].sy);
      @(negedge clk);
      check($sformatf("row%0d.tick", i), 32'(tick), 32'(vecs[i].tk));
      check($sformatf("row%0d.pend_busy", i), 32'(pend_busy), 32'(vecs[i].pb));
      check($sformatf("row%0d.cfg_ready", i), 32'(cfg_if.cfg_ready), 32'(vecs[i].rdy));
      check($sformatf("row%0d.cfg_err", i), 32'(cfg_if.cfg_err), 32'(vecs[i].err));
      next_cycle();
    end

    // Phase C: ch0 P=4 and ch1 P=6 out of phase, sync at k=0 and on ch0's
    // tick at k=8 while ch0 holds a staged P=2.
    do_reset();
    drive(1'b1, 3'd0, 1'b1, 16'd4, 1'b0); next_cycle();
    drive(1'b0, 3'd0, 1'b0, '0, 1'b0);    next_cycle();
    drive(1'b1, 3'd1, 1'b1, 16'd6, 1'b0); next_cycle();
    drive(1'b0, 3'd0, 1'b0, '0, 1'b0);    next_cycle();
    for (int i = 0; i < 4; i++) next_cycle();
    for (int k = 0; k <= 18; k++) begin
      logic [3:0] exp_tk;
      logic [3:0] exp_pb;
      drive(1'b0, 3'd0, 1'b0, '0, (k == 0) || (k == 8));
      if (k == 5)  drive(1'b1, 3'd0, 1'b1, 16'd2, 1'b0);
      if (k == 17) drive(1'b1, 3'd0, 1'b1, 16'd9, 1'b0);
      exp_tk    = '0;
      exp_tk[0] = (k == 4) || (k == 8) || (k >= 10 && k % 2 == 0);
      exp_tk[1] = (k == 6) || (k == 14);
      exp_pb    = '0;
      exp_pb[0] = (k == 7) || (k == 8);
      @(negedge clk);
      check($sformatf("sync k%0d.tick", k), 32'(tick), 32'(exp_tk));
      check($sformatf("sync k%0d.pend_busy", k), 32'(pend_busy), 32'(exp_pb));
      if (k == 6) check("sync k6.cfg_ready", 32'(cfg_if.cfg_ready), 32'h0);
      next_cycle();
    end

    // Phase D: ch0 running with staged P=9; reset drops everything.
    drive(1'b0, 3'd0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("midrst.pend_before", 32'(pend_busy), 32'h1);
    resetn = 1'b0;
    next_cycle();
    resetn = 1'b1;
    @(negedge clk);
    check("midrst.tick", 32'(tick), 32'h0);
    check("midrst.pend_busy", 32'(pend_busy), 32'h0);
    check("midrst.cfg_ready", 32'(cfg_if.cfg_ready), 32'h1);
    check("midrst.cfg_err", 32'(cfg_if.cfg_err), 32'h0);
    next_cycle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("postrst%0d.tick", i), 32'({tick, pend_busy}), 32'h0);
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Multi-channel periodic tick generator and rate controller for the flight-control fabric.
- Issues single-cycle enable strobes that pace sensor sampling, PWM update and control-loop logic, replacing free-running derived clocks with one clock plus enables.
- Per-channel period and enable are programmed at run time through a valid/ready config port.
- Period changes to a running channel are glitch-free: they take effect only at that channel's wrap.

Parameters:
NUM_CH, 4, number of tick channels (1..8)
WIDTH, 16, period/counter width in bits

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  synchronous active-low reset
cfg_valid  input  1  config request valid
cfg_ready  output  1  block can accept config this cycle
cfg_ch  input  3  target channel index
cfg_enable  input  1  1 = run channel, 0 = stop channel
cfg_period  input  WIDTH  tick period in clk cycles (>=1 when enabling)
cfg_err  output  1  one-cycle pulse: last accepted request rejected
sync_in  input  1  restart all running counters in phase
tick  output  NUM_CH  per-channel one-cycle strobe
pend_busy  output  NUM_CH  channel holds a not-yet-applied config

Behaviour:
- Reset: clk and resetn only; resetn low at a rising edge is reset.
- Reset values: tick=0, cfg_err=0, pend_busy=0, cfg_ready=1.
- Reset state: FSM in IDLE; all channels disabled with active_period=0, count=0, no pending.
- Reset mid-operation drops all pending configs.
- Per-channel state: active_en, active_period, count (WIDTH bits), pend_valid, pend_en, pend_period.
- tick[i] = active_en[i] && count[i]==active_period[i]-1. Derived from registered state, no input-to-output path.
- Counter: when active_en, count increments each cycle and wraps to 0 on the tick cycle. Period P therefore gives one tick every P cycles; P=1 gives tick high every cycle.
- Config FSM states: IDLE and COMMIT.
- IDLE: cfg_ready=1. A handshake in cycle T (cfg_valid && cfg_ready) latches the request and moves to COMMIT.
- COMMIT (cycle T+1): cfg_ready=0, returns to IDLE. cfg_ready is back to 1 at T+2, so there is at most one accept per 2 cycles.
- Validation happens in COMMIT. The request is rejected if cfg_ch>=NUM_CH, or if cfg_enable=1 with cfg_period=0.
- Rejected request: cfg_err=1 for cycle T+1 only; no state change.
- Accepted request, target channel disabled: applied at the end of T+1, with active_en=cfg_enable, active_period=cfg_period, count=0. First tick is at cycle T+1+P.
- Accepted request, cfg_enable=0 on a running channel: applied at the end of T+1. active_en=0, count=0, pending cleared. No tick after T+1.
- Accepted request, enable with new period on a running channel: written to pending at the end of T+1, and pend_busy[i]=1 from T+2.
- Pending apply: at the end of the channel's next tick cycle, active_period=pend_period and count=0, and pend_busy clears.
- The old period governs through that tick, so no short or long pulse interval is ever generated.
- A second write to a channel with pending set overwrites the pending value (last write wins).
- sync_in=1: all running channels set count=0 at the end of that cycle.
- sync_in coinciding with a channel's tick cycle: the tick is still emitted, and any pending config is still applied on that edge.
- Disabled channels ignore sync_in.
- Width rule: count and period are unsigned WIDTH bits; the max period is 2^WIDTH-1 and no wider arithmetic is needed.
- The comparison uses active_period-1, which is only evaluated when active_en=1, hence when the period is >=1.
- Channels are independent; multiple tick bits may be high in the same cycle.

Test Plan:
- Reset then program ch0 en=1 P=4 accepted at T: cfg_ready=0 at T+1; tick[0] at T+5, T+9, T+13; pend_busy=0 throughout.
- ch1 running P=3; write P=5 mid-interval: pend_busy[1]=1 until the next P=3 tick; after that, intervals are exactly 5 cycles with no intermediate tick.
- Write ch2 en=1 P=0, then cfg_ch=6 with NUM_CH=4: cfg_err pulses for 1 cycle each; tick and pend_busy stay 0.
- ch0 P=4 and ch1 P=6 running out of phase; pulse sync_in: both tick exactly 4 and 6 cycles after the sync cycle. sync_in on ch0's tick cycle still yields that tick.
- P=1 on ch3: tick[3] high every cycle. Then disable: tick[3] low from T+2 onward.
- Assert resetn=0 with ch0 pending and running: all outputs at reset values the next cycle; after release, no tick without reprogramming.
